// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends pattern[len-1:0] MSB-first, reps+1 times, with Moore outputs.
// Define SEQ_PATTERN_GEN_PARITY_EN to append an even-parity bit after every repetition.
module seq_pattern_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    output logic             x,
    output logic             x_vld,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    localparam logic [1:0] PAR  = 2'd2;
`endif
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] rep_q, rep_d;

    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] idx;
    logic             last_bit;
    logic             rep_end;
    logic             sel_bit;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    logic [WIDTH-1:0] par_mask;
    logic             par_bit;
`endif

    assign eff_len  = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign last_bit = (bit_q == len_q - 1'b1);
    assign idx      = len_q - 1'b1 - bit_q;

    always_comb begin
        sel_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == LEN_W'(i)) sel_bit = sr_q[i];
        end
    end

`ifdef SEQ_PATTERN_GEN_PARITY_EN
    // A shift by WIDTH yields zero, so a full-length pattern gets an all-ones mask.
    assign par_mask = ~({WIDTH{1'b1}} << len_q);
    assign par_bit  = ^(sr_q & par_mask);
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        len_d   = len_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        rep_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    sr_d    = pattern;
                    len_d   = eff_len;
                    bit_d   = '0;
                    rep_d   = reps;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_bit) begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                    state_d = PAR;
`else
                    rep_end = 1'b1;
`endif
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            PAR:     rep_end = 1'b1;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Zero is checked before decrementing, so the counter never underflows.
        if (rep_end) begin
            if (rep_q != '0) begin
                rep_d   = rep_q - 1'b1;
                bit_d   = '0;
                state_d = SEND;
            end else begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            sr_q    <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
        end
    end

    always_comb begin
        x     = 1'b0;
        x_vld = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            SEND: begin
                x     = sel_bit;
                x_vld = 1'b1;
                busy  = 1'b1;
            end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            PAR: begin
                x     = par_bit;
                x_vld = 1'b1;
                busy  = 1'b1;
            end
`endif
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule
